// File: rtl/imm_pkg.sv
// imm_pkg
//   Shared definitions for the RV32I immediate-decode stage:
//   major opcode values, the instruction-format enum and its width.
package imm_pkg;

    localparam int FMT_W = 3;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

endpackage

// File: rtl/imm_extract.sv
// imm_extract
//   Purely combinational immediate extractor. Classifies the instruction
//   format from the opcode and produces the sign-extended N-bit immediate.
// Ports:
//   instr   in   32  instruction word
//   fmt     out  3   format code (fmt_e)
//   imm     out  N   sign-extended immediate (0 for unrecognised opcodes)
//   illegal out  1   opcode not recognised
module imm_extract
    import imm_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [31:0]  instr,
    output fmt_e         fmt,
    output logic [N-1:0] imm,
    output logic         illegal
);

    // Every RV32I immediate fits in 32 bits once sign-extended from
    // instr[31]; widening to N is then a plain signed extension.
    function automatic logic [N-1:0] sext32(input logic signed [31:0] v);
        return N'(v);
    endfunction

    logic [31:0] raw;

    always_comb begin
        fmt     = FMT_NONE;
        raw     = '0;
        illegal = 1'b0;
        unique case (instr[6:0])
            OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM: begin
                fmt = FMT_I;
                raw = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt = FMT_S;
                raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                raw = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt = FMT_J;
                raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        imm = sext32(raw);
    end

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Registered immediate-decode stage between fetch and register-read.
//   Decodes on the input side, then buffers fully decoded entries in an
//   output register plus one skid register so the stage sustains one
//   instruction per cycle without a combinational out_ready -> in_ready path.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop held entries and the incoming instruction
//   in_valid/in_ready input handshake; in_ready = skid register empty
//   in_instr, in_pc   instruction word and address
//   out_valid/out_ready output handshake
//   out_instr, out_pc instruction and address passed through
//   out_imm, out_fmt  decoded immediate and format code
//   out_target        out_pc + out_imm (mod 2^N)
//   out_illegal       opcode not recognised
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_instr,
    input  logic [N-1:0] in_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_instr,
    output logic [N-1:0] out_pc,
    output logic [N-1:0] out_imm,
    output fmt_e         out_fmt,
    output logic [N-1:0] out_target,
    output logic         out_illegal
);

    typedef struct packed {
        logic [31:0]  instr;
        logic [N-1:0] pc;
        logic [N-1:0] imm;
        fmt_e         fmt;
        logic [N-1:0] target;
        logic         illegal;
    } entry_t;

    // ---- stage p0: decode and target add on the incoming instruction ----
    fmt_e         dec_fmt_p0;
    logic [N-1:0] dec_imm_p0;
    logic         dec_illegal_p0;
    entry_t       new_p0;

    imm_extract #(.N(N)) u_extract (
        .instr   (in_instr),
        .fmt     (dec_fmt_p0),
        .imm     (dec_imm_p0),
        .illegal (dec_illegal_p0)
    );

    always_comb begin
        new_p0.instr   = in_instr;
        new_p0.pc      = in_pc;
        new_p0.imm     = dec_imm_p0;
        new_p0.fmt     = dec_fmt_p0;
        new_p0.target  = in_pc + dec_imm_p0;
        new_p0.illegal = dec_illegal_p0;
    end

    // ---- stage p1: output register (or) and skid register (sk) ----
    entry_t or_p1;
    entry_t sk_p1;
    logic   vld_p1;
    logic   sk_vld_p1;

    logic accept_p0;
    logic drain_p1;

    assign in_ready  = !sk_vld_p1;
    assign accept_p0 = in_valid && in_ready && !flush;
    assign drain_p1  = vld_p1 && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            sk_vld_p1 <= 1'b0;
            or_p1     <= '0;
            sk_p1     <= '0;
        end else if (flush) begin
            // Data is left as-is; only validity is dropped.
            vld_p1    <= 1'b0;
            sk_vld_p1 <= 1'b0;
        end else if (drain_p1 || !vld_p1) begin
            // Output register is free this cycle: refill from skid first
            // to keep FIFO order, otherwise take the new entry directly.
            if (sk_vld_p1) begin
                or_p1     <= sk_p1;
                vld_p1    <= 1'b1;
                sk_vld_p1 <= accept_p0;
                if (accept_p0) begin
                    sk_p1 <= new_p0;
                end
            end else begin
                vld_p1 <= accept_p0;
                if (accept_p0) begin
                    or_p1 <= new_p0;
                end
            end
        end else if (accept_p0) begin
            // Output held by back-pressure: park the new entry in the skid.
            sk_p1     <= new_p0;
            sk_vld_p1 <= 1'b1;
        end
    end

    assign out_valid   = vld_p1;
    assign out_instr   = or_p1.instr;
    assign out_pc      = or_p1.pc;
    assign out_imm     = or_p1.imm;
    assign out_fmt     = or_p1.fmt;
    assign out_target  = or_p1.target;
    assign out_illegal = or_p1.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_instr, out_pc, out_imm, out_target;
    fmt_e        out_fmt;

    logic [63:0] in_pc64;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [31:0] out_instr64;
    logic [63:0] out_pc64, out_imm64, out_target64;
    fmt_e        out_fmt64;

    assign in_pc64 = {32'b0, in_pc};

    always #5 clk = ~clk;

    imm_decode_stage #(.N(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_target(out_target), .out_illegal(out_illegal)
    );

    imm_decode_stage #(.N(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_instr(out_instr64), .out_pc(out_pc64), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_target(out_target64), .out_illegal(out_illegal64)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] target;
        logic        illegal;
    } exp_t;

    exp_t q[$];

    // Reference decoder: sign-extends each format's narrow field directly.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e.instr   = ins;
        e.pc      = pc;
        e.illegal = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin
                e.fmt = 3'd1; e.imm = 32'($signed(ins[31:20]));
            end
            7'h23: begin
                e.fmt = 3'd2; e.imm = 32'($signed({ins[31:25], ins[11:7]}));
            end
            7'h63: begin
                e.fmt = 3'd3;
                e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4; e.imm = ins & 32'hFFFF_F000;
            end
            7'h6F: begin
                e.fmt = 3'd5;
                e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            default: begin
                e.fmt = 3'd0; e.imm = 32'h0; e.illegal = 1'b1;
            end
        endcase
        e.target = pc + e.imm;
        return e;
    endfunction

    // Scoreboard monitor and stall-stability check, sampled mid-cycle.
    logic        prev_stall = 1'b0;
    logic [31:0] hold_instr, hold_pc, hold_imm, hold_target;
    logic [2:0]  hold_fmt;
    logic        hold_illegal;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid",  out_valid,   1'b1);
                chk("stall_instr",  out_instr,   hold_instr);
                chk("stall_pc",     out_pc,      hold_pc);
                chk("stall_imm",    out_imm,     hold_imm);
                chk("stall_fmt",    out_fmt,     hold_fmt);
                chk("stall_target", out_target,  hold_target);
                chk("stall_illegal", out_illegal, hold_illegal);
            end
            prev_stall   = out_valid && !out_ready && !flush;
            hold_instr   = out_instr;
            hold_pc      = out_pc;
            hold_imm     = out_imm;
            hold_fmt     = out_fmt;
            hold_target  = out_target;
            hold_illegal = out_illegal;

            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", out_instr, 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_instr",   out_instr,   e.instr);
                    chk("sb_pc",      out_pc,      e.pc);
                    chk("sb_imm",     out_imm,     e.imm);
                    chk("sb_fmt",     out_fmt,     e.fmt);
                    chk("sb_target",  out_target,  e.target);
                    chk("sb_illegal", out_illegal, e.illegal);
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model(in_instr, in_pc));
        end
    end

    // Present an instruction and hold it until the edge that accepts it.
    // Returns 1 time unit after that edge with in_valid still asserted.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        logic rdy;
        bit   done;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        done     = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
        end
        #1;
        if (!done) chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (q.size() != 0 && c < 50) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'h0; in_pc = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_fmt",       out_fmt,   FMT_NONE);
        chk("rst_imm",       out_imm,   32'h0);
        @(posedge clk); #1;

        // I-type, checked on both widths
        send(32'hFFC1_2083, 32'h40);
        idle();
        @(negedge clk);
        chk("lw_valid",    out_valid,   1'b1);
        chk("lw_imm",      out_imm,     32'hFFFF_FFFC);
        chk("lw_fmt",      out_fmt,     FMT_I);
        chk("lw_target",   out_target,  32'h3C);
        chk("lw_illegal",  out_illegal, 1'b0);
        chk("lw64_imm",    out_imm64,   64'hFFFF_FFFF_FFFF_FFFC);
        chk("lw64_target", out_target64, 64'h3C);
        @(posedge clk); #1;

        // S then U on consecutive cycles
        in_valid = 1'b1; in_instr = 32'h0051_2423; in_pc = 32'h44;
        @(posedge clk); #1;
        in_instr = 32'h1234_50B7; in_pc = 32'h48;
        @(negedge clk);
        chk("sw_valid", out_valid, 1'b1);
        chk("sw_imm",   out_imm,   32'h8);
        chk("sw_fmt",   out_fmt,   FMT_S);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("lui_valid", out_valid, 1'b1);
        chk("lui_imm",   out_imm,   32'h1234_5000);
        chk("lui_fmt",   out_fmt,   FMT_U);
        @(posedge clk); #1;

        // Control flow
        send(32'hFE00_0CE3, 32'h100);
        idle();
        @(negedge clk);
        chk("beq_imm",    out_imm,    32'hFFFF_FFF8);
        chk("beq_fmt",    out_fmt,    FMT_B);
        chk("beq_target", out_target, 32'hF8);
        @(posedge clk); #1;
        send(32'h0010_006F, 32'h0);
        idle();
        @(negedge clk);
        chk("jal_imm",    out_imm,    32'h800);
        chk("jal_fmt",    out_fmt,    FMT_J);
        chk("jal_target", out_target, 32'h800);
        @(posedge clk); #1;

        // Back-pressure: out_ready low for three edges after the first accept
        fork
            begin
                send(32'h0040_0093, 32'h200);
                send(32'h0080_0113, 32'h204);
                send(32'h00C0_0193, 32'h208);
                send(32'h0100_0213, 32'h20C);
                send(32'h0140_0293, 32'h210);
                idle();
            end
            begin
                @(posedge clk); #1 out_ready = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", in_ready, 1'b0);
                chk("bp_out_held",     out_instr, 32'h0040_0093);
                @(posedge clk);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Flush with both entries full and an incoming instruction
        out_ready = 1'b0;
        send(32'h0000_0513, 32'h300);
        send(32'h0000_0593, 32'h304);
        idle();
        @(negedge clk);
        chk("fl_full_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = 32'h0000_0613; in_pc = 32'h308; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; idle();
        @(negedge clk);
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready",  in_ready,  1'b1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Illegal opcode
        send(32'h0000_007F, 32'h400);
        idle();
        @(negedge clk);
        chk("ill_illegal", out_illegal, 1'b1);
        chk("ill_imm",     out_imm,     32'h0);
        chk("ill_fmt",     out_fmt,     FMT_NONE);
        @(posedge clk); #1;

        // Reset with both entries full
        out_ready = 1'b0;
        send(32'h0000_0713, 32'h500);
        send(32'h0000_0793, 32'h504);
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid",   out_valid,   1'b0);
        chk("mrst_in_ready",    in_ready,    1'b1);
        chk("mrst_instr",       out_instr,   32'h0);
        chk("mrst_pc",          out_pc,      32'h0);
        chk("mrst_imm",         out_imm,     32'h0);
        chk("mrst_fmt",         out_fmt,     FMT_NONE);
        chk("mrst_target",      out_target,  32'h0);
        chk("mrst_illegal",     out_illegal, 1'b0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
